// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: machine width and the writeback payload beat.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_payload_t;

endpackage

// File: rtl/writeback_pkg.sv
// Writeback-local types: result-source identifiers and round-robin successor.
package writeback_pkg;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_CSR = 2'd1,
    SRC_LSU = 2'd2
  } src_e;

  function automatic src_e next_src(input src_e s);
    case (s)
      SRC_ALU: next_src = SRC_CSR;
      SRC_CSR: next_src = SRC_LSU;
      default: next_src = SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/writeback_if.sv
// AXI-stream style result channel carrying one wb_payload_t beat per handshake.
interface axis_if;
  import riscv_pkg::*;

  logic        tvalid;
  logic        tready;
  wb_payload_t tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/writeback_rr_arbiter.sv
// Three-way round-robin arbiter; pointer names the source with first priority.
module wb_rr_arbiter
  import writeback_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic [2:0] req,
  output logic [2:0] grant
);

  src_e ptr, ptr_next, scan, win;
  logic found;

  always_ff @(posedge clk) begin
    if (rst) ptr <= SRC_ALU;
    else     ptr <= ptr_next;
  end

  // Scan from the pointer in ALU -> CSR -> LSU order; first requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    scan  = ptr;
    win   = ptr;
    for (int unsigned i = 0; i < 3; i++) begin
      if (!found && req[scan]) begin
        grant[scan] = 1'b1;
        found       = 1'b1;
        win         = scan;
      end
      scan = next_src(scan);
    end
    ptr_next = (found && !flush) ? next_src(win) : ptr;
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: arbitrates ALU/CSR/LSU results into the register-file write port.
module writeback
  import riscv_pkg::*;
#(
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  axis_if.s                    aluwb_axis_if,
  axis_if.s                    csrwb_axis_if,
  axis_if.s                    lsuwb_axis_if,
  input  logic                 invalidate,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [INSTRET_W-1:0] instret
);

  logic [2:0]  req, grant;
  logic        accept, beat_we;
  logic        out_valid, out_we;
  wb_payload_t beat;

  assign req = {lsuwb_axis_if.tvalid, csrwb_axis_if.tvalid, aluwb_axis_if.tvalid};

  wb_rr_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .flush (invalidate),
    .req   (req),
    .grant (grant)
  );

  // A flush drains every source at once; reset blocks all of them.
  assign aluwb_axis_if.tready = !rst && (invalidate || grant[0]);
  assign csrwb_axis_if.tready = !rst && (invalidate || grant[1]);
  assign lsuwb_axis_if.tready = !rst && (invalidate || grant[2]);

  always_comb begin
    beat = aluwb_axis_if.tdata;
    if (grant[1]) beat = csrwb_axis_if.tdata;
    if (grant[2]) beat = lsuwb_axis_if.tdata;
  end

  assign accept  = !rst && !invalidate && (grant != '0);
  assign beat_we = beat.we && (beat.rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_we    <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      instret   <= '0;
    end else begin
      if (out_valid && !invalidate) instret <= instret + INSTRET_W'(1);
      if (invalidate) begin
        out_valid <= 1'b0;
        out_we    <= 1'b0;
      end else begin
        out_valid <= accept;
        out_we    <= accept && beat_we;
        // Address/data only move on a real write so they hold otherwise.
        if (accept && beat_we) begin
          rf_waddr <= beat.rd;
          rf_wdata <= beat.data;
        end
      end
    end
  end

  assign rf_we = out_we && !invalidate;

endmodule
